branch_predict_unit: RTL and testbench

//  Next-generation PC-source block: resolves branch/jump outcome in EX and adds a

---
 rtl/branch_pkg.sv | 31 +++
 rtl/branch_cond_eval.sv | 29 ++
 rtl/branch_predict_unit.sv | 144 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor slice:
// funct3 encodings, 2-bit counter states, init FSM states.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } bht_state_t;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] cnt_next(input logic [1:0] c,
                                            input logic taken);
        logic [1:0] r;
        if (taken) r = (c == ST) ? ST : c + 2'd1;
        else       r = (c == SNT) ? SNT : c - 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Conditional-branch decode: funct3 plus ALU flags
// give the taken outcome and an illegal-encoding flag.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       u_slt,
    input  logic       s_slt,
    output logic       taken,
    output logic       illegal
);

    // Map each funct3 encoding onto the matching flag.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        unique case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = s_slt;
            F3_BGE:  taken = ~s_slt;
            F3_BLTU: taken = u_slt;
            F3_BGEU: taken = ~u_slt;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// PC-source block: EX branch resolution, 2-bit BHT
// prediction, registered mispredict redirect, perf counters.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic            init_done,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_zero,
    input  logic            ex_u_slt,
    input  logic            ex_s_slt,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            ex_taken,
    output logic            ex_illegal,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int DEPTH = 2 ** IDX_W;

    bht_state_t       state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic [1:0]       bht [DEPTH];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic             cond_taken, cond_illegal;
    logic             is_run, update, mispredict;
    logic [1:0]       cur_cnt;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                              ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    branch_cond_eval u_cond (
        .funct3  (ex_funct3),
        .zero    (ex_zero),
        .u_slt   (ex_u_slt),
        .s_slt   (ex_s_slt),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    // Resolve: jump wins over branch; nothing resolves without ex_valid.
    always_comb begin
        ex_taken   = 1'b0;
        ex_illegal = 1'b0;
        if (ex_valid) begin
            if (ex_jump) begin
                ex_taken = 1'b1;
            end else if (ex_branch) begin
                ex_taken   = cond_taken;
                ex_illegal = cond_illegal;
            end
        end
    end

    assign is_run     = (state_q == S_RUN);
    assign update     = is_run & ex_valid & ex_branch & ~ex_illegal;
    assign mispredict = ex_valid & (ex_branch | ex_jump) & ~ex_illegal &
                        (ex_taken != ex_pred_taken);
    assign cur_cnt    = bht[ex_idx];

    assign init_done     = is_run;
    assign if_pred_taken = is_run & bht[if_idx][1];

    // Init FSM next state: sweep every entry once, then run.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        unique case (state_q)
            S_INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == IDX_W'(DEPTH - 1)) state_d = S_RUN;
            end
            S_RUN: begin
                init_idx_d = '0;
            end
            default: begin
                state_d    = S_INIT;
                init_idx_d = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // BHT write port: init fill, or counter update at resolve.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT) bht[init_idx_q] <= WNT;
            else if (update)       bht[ex_idx] <= cnt_next(cur_cnt, ex_taken);
        end
    end

    // Redirect register: one-cycle pulse, PC held between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict)
                redirect_pc <= ex_taken ? ex_target : ex_pc + XLEN'(4);
        end
    end

    // Performance counters, frozen during init.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (is_run) begin
            if (update)     branch_cnt  <= branch_cnt + 1'b1;
            if (mispredict) mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: resolve table
// plus hand sequences for init, BHT, redirect and reset.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken, init_done;
    logic        ex_valid, ex_branch, ex_jump;
    logic [2:0]  ex_funct3;
    logic        ex_zero, ex_u_slt, ex_s_slt;
    logic [31:0] ex_pc, ex_target;
    logic        ex_pred_taken, ex_taken, ex_illegal;
    logic        redirect_valid;
    logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid, branch, jump;
        logic [2:0] f3;
        logic       zero, u, s;
        logic       exp_taken, exp_illegal;
    } vec_t;

    vec_t tbl [17];

    branch_predict_unit dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .init_done(init_done),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_funct3(ex_funct3), .ex_zero(ex_zero), .ex_u_slt(ex_u_slt),
        .ex_s_slt(ex_s_slt), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken),
        .ex_illegal(ex_illegal), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_funct3 = 0;
        ex_zero = 0; ex_u_slt = 0; ex_s_slt = 0;
        ex_pc = 0; ex_target = 0; ex_pred_taken = 0;
    endtask

    task automatic br(input logic [2:0] f3, input logic z,
                      input logic s, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic pred);
        ex_valid = 1; ex_branch = 1; ex_jump = 0; ex_funct3 = f3;
        ex_zero = z; ex_u_slt = 0; ex_s_slt = s;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
    endtask

    task automatic do_reset_and_init(input string tag);
        int n;
        logic saw_pred;
        rst = 1;
        step();
        rst = 0;
        chk({tag, "_rst_rv"}, 32'(redirect_valid), 0);
        chk({tag, "_rst_bcnt"}, branch_cnt, 0);
        chk({tag, "_rst_mcnt"}, mispred_cnt, 0);
        chk({tag, "_rst_done"}, 32'(init_done), 0);
        n = 0;
        saw_pred = 0;
        while (n < 200) begin
            if (if_pred_taken) saw_pred = 1;
            step();
            n++;
            if (init_done) break;
        end
        chk({tag, "_init_cycles"}, 32'(n), 64);
        chk({tag, "_init_pred0"}, 32'(saw_pred), 0);
    endtask

    initial begin
        // resolve table: valid branch jump f3 zero u s -> taken illegal
        tbl[0]  = '{1, 1, 0, 3'b000, 1, 0, 0, 1, 0};
        tbl[1]  = '{1, 1, 0, 3'b000, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 3'b001, 0, 0, 0, 1, 0};
        tbl[3]  = '{1, 1, 0, 3'b001, 1, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 0, 3'b100, 0, 0, 1, 1, 0};
        tbl[5]  = '{1, 1, 0, 3'b100, 0, 1, 0, 0, 0};
        tbl[6]  = '{1, 1, 0, 3'b101, 0, 1, 0, 1, 0};
        tbl[7]  = '{1, 1, 0, 3'b101, 0, 0, 1, 0, 0};
        tbl[8]  = '{1, 1, 0, 3'b110, 0, 1, 0, 1, 0};
        tbl[9]  = '{1, 1, 0, 3'b110, 0, 0, 1, 0, 0};
        tbl[10] = '{1, 1, 0, 3'b111, 0, 0, 1, 1, 0};
        tbl[11] = '{1, 1, 0, 3'b111, 0, 1, 0, 0, 0};
        tbl[12] = '{1, 1, 0, 3'b010, 1, 1, 1, 0, 1};
        tbl[13] = '{1, 1, 0, 3'b011, 1, 1, 1, 0, 1};
        tbl[14] = '{1, 1, 1, 3'b000, 0, 0, 0, 1, 0};
        tbl[15] = '{1, 0, 1, 3'b000, 0, 0, 0, 1, 0};
        tbl[16] = '{0, 1, 0, 3'b000, 1, 0, 0, 0, 0};

        if_pc = 0;
        idle();
        do_reset_and_init("boot");

        // beq taken, predicted not taken -> redirect to target
        br(3'b000, 1, 0, 32'h100, 32'h80, 0);
        #1 chk("beq_taken", 32'(ex_taken), 1);
        step();
        idle();
        chk("beq_rv", 32'(redirect_valid), 1);
        chk("beq_rpc", redirect_pc, 32'h80);
        chk("beq_bcnt", branch_cnt, 1);
        chk("beq_mcnt", mispred_cnt, 1);
        step();
        chk("pulse_rv", 32'(redirect_valid), 0);
        chk("hold_rpc", redirect_pc, 32'h80);

        // bge with s_slt=1 is not taken, predicted taken -> pc+4
        br(3'b101, 0, 1, 32'h200, 32'h999, 1);
        step();
        idle();
        chk("bge_rv", 32'(redirect_valid), 1);
        chk("bge_rpc", redirect_pc, 32'h204);
        chk("bge_bcnt", branch_cnt, 2);
        chk("bge_mcnt", mispred_cnt, 2);

        // counter walk at pc 0x40 (index 16), starting at 01
        if_pc = 32'h40;
        #1 chk("bht_init_pred", 32'(if_pred_taken), 0);
        br(3'b000, 1, 0, 32'h40, 32'h10, 1);
        #1 chk("bht_rdw_old", 32'(if_pred_taken), 0);
        step();
        chk("bht_t1_pred", 32'(if_pred_taken), 1);
        step();
        chk("bht_t2_pred", 32'(if_pred_taken), 1);
        step();
        chk("bht_t3_pred", 32'(if_pred_taken), 1);
        chk("bht_t3_mcnt", mispred_cnt, 2);
        br(3'b000, 0, 0, 32'h40, 32'h10, 0);
        step();
        chk("bht_n1_pred", 32'(if_pred_taken), 1);
        step();
        chk("bht_n2_pred", 32'(if_pred_taken), 0);
        step();
        step();
        br(3'b000, 1, 0, 32'h40, 32'h10, 0);
        step();
        chk("bht_sat0_pred", 32'(if_pred_taken), 0);
        idle();
        #1 chk("bht_walk_bcnt", branch_cnt, 10);
        chk("bht_walk_mcnt", mispred_cnt, 3);
        br(3'b000, 1, 0, 32'h40, 32'h10, 1);
        step();
        idle();
        chk("bht_up_pred", 32'(if_pred_taken), 1);

        // jump: no BHT update, no branch count, redirect to target
        ex_valid = 1; ex_jump = 1; ex_pc = 32'h40; ex_target = 32'h300;
        ex_pred_taken = 0;
        step();
        idle();
        chk("jmp_rpc", redirect_pc, 32'h300);
        chk("jmp_bcnt", branch_cnt, 11);
        chk("jmp_mcnt", mispred_cnt, 4);
        chk("jmp_pred", 32'(if_pred_taken), 1);

        // not-taken at top of address space wraps pc+4 to 0
        br(3'b001, 1, 0, 32'hFFFF_FFFC, 32'h1234, 1);
        step();
        idle();
        chk("wrap_rv", 32'(redirect_valid), 1);
        chk("wrap_rpc", redirect_pc, 32'h0);

        // illegal funct3: no update, no redirect even with pred=1
        br(3'b010, 1, 0, 32'h40, 32'h500, 1);
        #1 chk("ill_flag", 32'(ex_illegal), 1);
        chk("ill_taken", 32'(ex_taken), 0);
        step();
        idle();
        chk("ill_rv", 32'(redirect_valid), 0);
        chk("ill_bcnt", branch_cnt, 12);
        chk("ill_mcnt", mispred_cnt, 5);
        chk("ill_pred", 32'(if_pred_taken), 1);

        // ex_valid low: nothing resolves
        br(3'b000, 1, 0, 32'h100, 32'h80, 0);
        ex_valid = 0;
        #1 chk("inv_taken", 32'(ex_taken), 0);
        step();
        idle();
        chk("inv_rv", 32'(redirect_valid), 0);
        chk("inv_mcnt", mispred_cnt, 5);

        // resolve table; prediction matches so no redirects occur
        for (int i = 0; i < 17; i++) begin
            ex_valid = tbl[i].valid; ex_branch = tbl[i].branch;
            ex_jump = tbl[i].jump; ex_funct3 = tbl[i].f3;
            ex_zero = tbl[i].zero; ex_u_slt = tbl[i].u;
            ex_s_slt = tbl[i].s; ex_pc = 32'h1000;
            ex_target = 32'h2000; ex_pred_taken = tbl[i].exp_taken;
            #1;
            chk($sformatf("tbl%0d_taken", i), 32'(ex_taken),
                32'(tbl[i].exp_taken));
            chk($sformatf("tbl%0d_illegal", i), 32'(ex_illegal),
                32'(tbl[i].exp_illegal));
            step();
        end
        idle();
        #1 chk("tbl_mcnt", mispred_cnt, 5);

        // reset mid-run with a mispredict pending on the inputs
        br(3'b000, 1, 0, 32'h100, 32'h80, 0);
        rst = 1;
        step();
        idle();
        rst = 0;
        chk("mid_rv", 32'(redirect_valid), 0);
        chk("mid_rpc", redirect_pc, 0);
        chk("mid_done", 32'(init_done), 0);
        chk("mid_pred", 32'(if_pred_taken), 0);
        do_reset_and_init("rerun");
        if_pc = 32'h40;
        #1 chk("reinit_pred", 32'(if_pred_taken), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
